// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg
// Shared definitions for the sequential signed multiplier: controller state
// type with its explicit encodings, and the default values for the operand
// width and the fault-injection period.
package seq_mult_pkg;

  localparam int DEFAULT_W            = 8;
  localparam int DEFAULT_FAULT_PERIOD = 10;

  localparam logic [1:0] IDLE_ENC = 2'd0;
  localparam logic [1:0] RUN_ENC  = 2'd1;
  localparam logic [1:0] FIX_ENC  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = IDLE_ENC,
    RUN  = RUN_ENC,
    FIX  = FIX_ENC
  } state_t;

endpackage

// File: rtl/seq_mult_dp.sv
// seq_mult_dp
// Unsigned radix-2 shift-add datapath. It multiplies two W-bit magnitudes
// over W step cycles.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   load       capture a_mag/b_mag, clear accumulator, counter = W
//   step       perform one shift-add step and decrement the counter
//   a_mag      multiplicand magnitude (W bits, unsigned)
//   b_mag      multiplier magnitude (W bits, unsigned)
//   mag        accumulated unsigned product (2W bits)
//   last_step  high while the counter shows the final step is pending
module seq_mult_dp
  import seq_mult_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   a_mag,
  input  logic [W-1:0]   b_mag,
  output logic [2*W-1:0] mag,
  output logic           last_step
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  count;

  // The multiplicand moves left while the multiplier moves right. The
  // multiplier LSB therefore always selects the correctly weighted partial
  // product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      mag    <= '0;
      count  <= '0;
    end else if (load) begin
      mcand  <= {{W{1'b0}}, a_mag};
      mplier <= b_mag;
      mag    <= '0;
      count  <= CW'(W);
    end else if (step) begin
      if (mplier[0]) begin
        mag <= mag + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CW'(1);
    end
  end

  assign last_step = (count == CW'(1));

endmodule

// File: rtl/seq_mult.sv
// seq_mult
// Sequential 2's-complement multiplier. It takes the magnitudes of both
// operands, multiplies them with the shift-add datapath, and applies the
// sign in a final FIX cycle. The latency from the start-sampling edge to
// done is W+1 edges.
// Optional feature: define MULT_FAULT_INJECT_EN to arithmetically halve
// every FAULT_PERIOD-th result.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   start     operation request (accepted only in IDLE)
//   a, b      W-bit signed operands
//   r         2W-bit signed product, registered, held until the next result
//   done      one-cycle completion pulse
//   busy      operation in progress
//   valid     r holds the result of the most recent operation
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int W            = DEFAULT_W,
  parameter int FAULT_PERIOD = DEFAULT_FAULT_PERIOD
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] r,
  output logic           done,
  output logic           busy,
  output logic           valid
);

  if (W < 2 || FAULT_PERIOD < 1) begin : g_bad_params
    $error("seq_mult: W must be >= 2 and FAULT_PERIOD must be >= 1");
  end

  state_t         state, state_nxt;
  logic           dp_load, dp_step, fix_en;
  logic           last_step;
  logic           sign;
  logic [W-1:0]   a_mag, b_mag;
  logic [2*W-1:0] mag, exact, result;

  // The most negative value maps onto 2^(W-1). That still fits as a W-bit
  // unsigned value, so no widening is needed.
  assign a_mag = a[W-1] ? (~a + W'(1)) : a;
  assign b_mag = b[W-1] ? (~b + W'(1)) : b;

  seq_mult_dp #(.W(W)) u_dp (
    .clk       (clk),
    .rst       (rst),
    .load      (dp_load),
    .step      (dp_step),
    .a_mag     (a_mag),
    .b_mag     (b_mag),
    .mag       (mag),
    .last_step (last_step)
  );

  // Negating a zero magnitude wraps back to zero. Therefore no negative zero
  // can appear.
  assign exact = sign ? (~mag + (2*W)'(1)) : mag;

`ifdef MULT_FAULT_INJECT_EN
  localparam int FW = $clog2(FAULT_PERIOD + 1);

  logic [FW-1:0] fault_cnt;
  logic          fault_now;

  assign fault_now = (fault_cnt == FW'(FAULT_PERIOD - 1));
  assign result    = fault_now ? {exact[2*W-1], exact[2*W-1:1]} : exact;

  // Counts completed operations. It wraps on the faulty one, so every
  // FAULT_PERIOD-th completion is corrupted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_cnt <= '0;
    end else if (fix_en) begin
      fault_cnt <= fault_now ? '0 : fault_cnt + FW'(1);
    end
  end
`else
  assign result = exact;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dp_load = (state == IDLE) && start;
    dp_step = (state == RUN);
    fix_en  = (state == FIX);
  end

  // The outputs are registered. done defaults low, so it stays high only for
  // the single cycle that follows the FIX edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign  <= 1'b0;
      r     <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      done <= 1'b0;
      if (dp_load) begin
        sign  <= a[W-1] ^ b[W-1];
        busy  <= 1'b1;
        valid <= 1'b0;
      end
      if (fix_en) begin
        r     <= result;
        done  <= 1'b1;
        valid <= 1'b1;
        busy  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/seq_mult.md
SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 SHALL have parameter W, default 8, meaning operand width in bits; legal range W >= 2.
REQ-002 SHALL have parameter FAULT_PERIOD, default 10, meaning the completed-operation count between injected faults; it is used only when MULT_FAULT_INJECT_EN is defined.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 start  input  1  operation request, sampled on rising clk.
REQ-006 a  input  W  multiplicand, 2's complement.
REQ-007 b  input  W  multiplier, 2's complement.
REQ-008 r  output  2W  product, 2's complement, registered.
REQ-009 done  output  1  one-cycle completion pulse, registered.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 valid  output  1  high while r holds the result of the most recent operation.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and FIX.
REQ-013 In IDLE, an edge with start=1 SHALL do all of: capture |a| and |b| as W-bit unsigned values; capture sign = a[W-1] XOR b[W-1]; clear the accumulator; load iteration counter = W; set busy=1 and valid=0; go to RUN.
REQ-014 In RUN, each edge SHALL perform one radix-2 shift-add step using the multiplier LSB, then decrement the counter; after W steps it SHALL go to FIX.
REQ-015 In FIX, one edge SHALL register r = sign ? (~mag + 1) : mag over 2W bits; set done=1, valid=1 and busy=0; go to IDLE.
REQ-016 done SHALL be high for exactly the one cycle following the FIX edge, which is W+1 edges after the start-sampling edge. Throughput SHALL be one operation per W+2 cycles.
REQ-017 start SHALL be ignored in RUN and FIX; a, b and start SHALL NOT be required stable after the sampling edge.
REQ-018 start=1 during the done cycle SHALL be accepted, because the FSM is then in IDLE. This gives back-to-back operation.
REQ-019 r SHALL hold its value until the next FIX edge; valid SHALL drop on the accepting edge of a new start.
REQ-020 Most-negative operands SHALL be exact: |-2^(W-1)| = 2^(W-1) fits in W unsigned bits, and (-2^(W-1))^2 fits in 2W signed bits.
REQ-021 A zero operand SHALL produce r=0 with no negative zero, whatever the operand signs.

Reset
REQ-022 While rst=1, and immediately on its assertion, the block SHALL force: state=IDLE, r=0, done=0, busy=0, valid=0, and fault counter=0.
REQ-023 Reset asserted mid-operation SHALL abandon that operation with no done pulse.
REQ-024 The first start after rst deassertion SHALL be accepted normally.

Configuration
REQ-025 Macro MULT_FAULT_INJECT_EN enables the fault-injection feature.
REQ-026 With MULT_FAULT_INJECT_EN defined, a counter of completed operations SHALL run. On every FAULT_PERIOD-th completion, r SHALL be the correct product arithmetically shifted right by one bit, and the counter SHALL then return to 0. done, valid and latency SHALL be unchanged.
REQ-027 Without MULT_FAULT_INJECT_EN, the fault counter SHALL NOT exist and every result SHALL be exact.

Structure
REQ-028 Package seq_mult_pkg SHALL hold: the state enum typedef (IDLE, RUN, FIX), its encoding constants, and the default values of W and FAULT_PERIOD.
REQ-029 The shift-add datapath (magnitude registers, accumulator, counter) SHALL be sub-module seq_mult_dp; the FSM, sign handling and fault logic SHALL stay in seq_mult.

Verification (W=8)
REQ-030 a=3, b=5, start for one cycle -> done pulses 9 edges later, r=16'h000F, valid=1, busy low.
REQ-031 a=-128, b=-128 -> r=16'h4000; a=-7, b=9 -> r=16'hFFC1; a=0, b=-5 -> r=16'h0000.
REQ-032 start pulsed at edge 3 of a busy operation with different operands -> ignored; exactly one done; r equals the first operation's product.
REQ-033 rst asserted at edge 4 of an operation -> r=0, busy=0, valid=0 immediately; no done pulse; the next start with a=2, b=2 gives r=4.
REQ-034 Ten back-to-back operations with a=6, b=7, start held high -> done every 10 cycles. With MULT_FAULT_INJECT_EN defined, the 10th r=21 and all others 42. Without it, all r=42.
